// File: rtl/lcd_fill_rect_if.sv
// Request/handshake bundle for the rectangle-fill engine: the start request
// and window on one side, the {dc, byte} word stream to the SPI writer on
// the other.
interface lcd_fill_rect_if;
  logic        fill_flag;
  logic [7:0]  x0;
  logic [7:0]  y0;
  logic [7:0]  x1;
  logic [7:0]  y1;
  logic [15:0] color;
  logic        wr_done;
  logic [8:0]  fill_data;
  logic        en_write_fill;
  logic        busy;
  logic        fill_done;

  // The fill engine drives the word stream and status.
  modport master (
    input  fill_flag, x0, y0, x1, y1, color, wr_done,
    output fill_data, en_write_fill, busy, fill_done
  );

  // The requester / SPI writer side.
  modport slave (
    output fill_flag, x0, y0, x1, y1, color, wr_done,
    input  fill_data, en_write_fill, busy, fill_done
  );
endinterface

// File: rtl/lcd_fill_rect.sv
// ST7735 rectangle fill: on a start pulse, latch a window and RGB565 colour,
// then stream CASET/RASET/RAMWR followed by W*H two-byte pixels as 9-bit
// {dc, byte} words, one word per en_write_fill/wr_done handshake.
module lcd_fill_rect #(
  parameter logic [7:0] X_OFFSET = 8'd2,
  parameter logic [7:0] Y_OFFSET = 8'd3
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  lcd_fill_rect_if.master  bus
);

  // NEXT is kept in the encoding for readability of the sequence, but the
  // index advance is folded into the WAIT->ISSUE transition so the next
  // strobe follows wr_done with no bubble cycle.
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;

  state_t      state;
  logic [7:0]  x0_q;
  logic [7:0]  y0_q;
  logic [7:0]  x1_q;
  logic [7:0]  y1_q;
  logic [15:0] color_q;
  logic [7:0]  col_last;
  logic [7:0]  row_last;
  logic [3:0]  hdr_idx;
  logic        pix_phase;
  logic        lo_byte;
  logic [7:0]  col;
  logic [7:0]  row;
  logic [3:0]  hdr_next_idx;
  logic [8:0]  hdr_next_word;
  logic        last_col;
  logic        last_row;

  assign hdr_next_idx = hdr_idx + 4'd1;
  assign last_col     = (col == col_last);
  assign last_row     = (row == row_last);

  // Header word that follows the current header index (word 0 is issued on accept).
  always_comb begin
    hdr_next_word = 9'h000;
    case (hdr_next_idx)
      4'd1, 4'd3, 4'd6, 4'd8: hdr_next_word = 9'h100;
      4'd2:  hdr_next_word = {1'b1, 8'(x0_q + X_OFFSET)};
      4'd4:  hdr_next_word = {1'b1, 8'(x1_q + X_OFFSET)};
      4'd5:  hdr_next_word = 9'h02B;
      4'd7:  hdr_next_word = {1'b1, 8'(y0_q + Y_OFFSET)};
      4'd9:  hdr_next_word = {1'b1, 8'(y1_q + Y_OFFSET)};
      4'd10: hdr_next_word = 9'h02C;
      default: hdr_next_word = 9'h000;
    endcase
  end

  // Sequencer: accept, header words, pixel bytes with column/row counters, completion pulse.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state             <= IDLE;
      bus.fill_data     <= 9'h000;
      bus.en_write_fill <= 1'b0;
      bus.busy          <= 1'b0;
      bus.fill_done     <= 1'b0;
      x0_q              <= 8'd0;
      y0_q              <= 8'd0;
      x1_q              <= 8'd0;
      y1_q              <= 8'd0;
      color_q           <= 16'd0;
      col_last          <= 8'd0;
      row_last          <= 8'd0;
      hdr_idx           <= 4'd0;
      pix_phase         <= 1'b0;
      lo_byte           <= 1'b0;
      col               <= 8'd0;
      row               <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          bus.fill_done <= 1'b0;
          if (bus.fill_flag) begin
            x0_q      <= bus.x0;
            y0_q      <= bus.y0;
            x1_q      <= bus.x1;
            y1_q      <= bus.y1;
            color_q   <= bus.color;
            col_last  <= bus.x1 - bus.x0;
            row_last  <= bus.y1 - bus.y0;
            hdr_idx   <= 4'd0;
            pix_phase <= 1'b0;
            lo_byte   <= 1'b0;
            col       <= 8'd0;
            row       <= 8'd0;
            if ((bus.x1 < bus.x0) || (bus.y1 < bus.y0)) begin
              state         <= DONE;
              bus.fill_done <= 1'b1;
            end else begin
              state             <= ISSUE;
              bus.fill_data     <= 9'h02A;
              bus.en_write_fill <= 1'b1;
              bus.busy          <= 1'b1;
            end
          end
        end
        ISSUE: begin
          bus.en_write_fill <= 1'b0;
          state             <= WAIT;
        end
        WAIT: begin
          if (bus.wr_done) begin
            if (!pix_phase) begin
              if (hdr_idx == 4'd10) begin
                pix_phase     <= 1'b1;
                lo_byte       <= 1'b0;
                bus.fill_data <= {1'b1, color_q[15:8]};
              end else begin
                hdr_idx       <= hdr_next_idx;
                bus.fill_data <= hdr_next_word;
              end
              bus.en_write_fill <= 1'b1;
              state             <= ISSUE;
            end else if (!lo_byte) begin
              lo_byte           <= 1'b1;
              bus.fill_data     <= {1'b1, color_q[7:0]};
              bus.en_write_fill <= 1'b1;
              state             <= ISSUE;
            end else if (last_col && last_row) begin
              bus.busy      <= 1'b0;
              bus.fill_done <= 1'b1;
              state         <= DONE;
            end else begin
              lo_byte           <= 1'b0;
              bus.fill_data     <= {1'b1, color_q[15:8]};
              bus.en_write_fill <= 1'b1;
              state             <= ISSUE;
              if (last_col) begin
                col <= 8'd0;
                row <= row + 8'd1;
              end else begin
                col <= col + 8'd1;
              end
            end
          end
        end
        DONE: begin
          bus.fill_done <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          bus.en_write_fill <= 1'b0;
          bus.busy          <= 1'b0;
          bus.fill_done     <= 1'b0;
          state             <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_fill_rect.sv
// Testbench for lcd_fill_rect: table-driven windows plus randomized windows,
// each stream checked word by word against a queue built from the window
// arithmetic, with a cycle-accurate SPI-writer model driving wr_done.
module tb_lcd_fill_rect;

  localparam int CYCLE_LIMIT = 30000;

  typedef struct {
    string      name;
    logic [7:0] x0;
    logic [7:0] y0;
    logic [7:0] x1;
    logic [7:0] y1;
    logic [15:0] color;
    int         max_delay;
    int         exp_words;
  } vec_t;

  typedef enum {P_STROBE, P_HOLD, P_DONE, P_AFTER} phase_t;

  logic sys_clk;
  logic sys_rst_n;
  int   checks;
  int   errors;
  logic [8:0] exp_q[$];

  lcd_fill_rect_if bus ();

  lcd_fill_rect dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    bus.wr_done   = 1'b0;
    bus.fill_flag = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  // Expected word stream from the window rules, using plain arithmetic.
  task automatic buildExpected(input logic [7:0] ax0, input logic [7:0] ay0,
                               input logic [7:0] ax1, input logic [7:0] ay1,
                               input logic [15:0] acolor);
    logic [7:0] b;
    exp_q.delete();
    if (ax1 < ax0 || ay1 < ay0) return;
    exp_q.push_back(9'h02A);
    exp_q.push_back(9'h100);
    b = 8'((int'(ax0) + 2) % 256); exp_q.push_back({1'b1, b});
    exp_q.push_back(9'h100);
    b = 8'((int'(ax1) + 2) % 256); exp_q.push_back({1'b1, b});
    exp_q.push_back(9'h02B);
    exp_q.push_back(9'h100);
    b = 8'((int'(ay0) + 3) % 256); exp_q.push_back({1'b1, b});
    exp_q.push_back(9'h100);
    b = 8'((int'(ay1) + 3) % 256); exp_q.push_back({1'b1, b});
    exp_q.push_back(9'h02C);
    for (int r = 0; r <= int'(ay1) - int'(ay0); r++)
      for (int c = 0; c <= int'(ax1) - int'(ax0); c++) begin
        exp_q.push_back({1'b1, acolor[15:8]});
        exp_q.push_back({1'b1, acolor[7:0]});
      end
  endtask

  // Accept a window on the next edge, then release the request.
  task automatic applyStimulus(input logic [7:0] ax0, input logic [7:0] ay0,
                               input logic [7:0] ax1, input logic [7:0] ay1,
                               input logic [15:0] acolor);
    @(negedge sys_clk);
    bus.x0 = ax0; bus.y0 = ay0; bus.x1 = ax1; bus.y1 = ay1; bus.color = acolor;
    bus.fill_flag = 1'b1;
    @(negedge sys_clk);
    bus.fill_flag = 1'b0;
    bus.x0 = 8'($urandom); bus.y0 = 8'($urandom);
    bus.x1 = 8'($urandom); bus.y1 = 8'($urandom);
    bus.color = 16'($urandom);
  endtask

  // Run one fill against exp_q, acting as the SPI writer; one step per negedge.
  task automatic runFill(input string tag,
                         input logic [7:0] ax0, input logic [7:0] ay0,
                         input logic [7:0] ax1, input logic [7:0] ay1,
                         input logic [15:0] acolor,
                         input int max_delay, input int mid_pulse_at,
                         input bit pulse_in_done, input int reset_at_word,
                         output int strobes);
    phase_t     phase;
    int         k;
    int         delay;
    int         cycles;
    bit         finished;
    logic [8:0] held;
    k = 0; delay = 0; cycles = 0; finished = 0; held = 9'h000;
    applyStimulus(ax0, ay0, ax1, ay1, acolor);
    phase = (exp_q.size() == 0) ? P_DONE : P_STROBE;
    while (!finished && cycles < CYCLE_LIMIT) begin
      bus.wr_done   = 1'b0;
      bus.fill_flag = 1'b0;
      if (cycles == mid_pulse_at) begin
        bus.fill_flag = 1'b1;
        bus.x0 = 8'($urandom); bus.y0 = 8'($urandom);
        bus.x1 = 8'($urandom); bus.y1 = 8'($urandom);
        bus.color = 16'($urandom);
      end
      case (phase)
        P_STROBE: begin
          checkOutput({tag, " strobe"}, bus.en_write_fill, 1'b1);
          if (bus.en_write_fill !== 1'b1) begin
            finished = 1;
            doReset();
          end else begin
            checkOutput({tag, " word"}, bus.fill_data, (k < exp_q.size()) ? exp_q[k] : 9'h1FF);
            checkOutput({tag, " busy at strobe"}, bus.busy, 1'b1);
            held  = bus.fill_data;
            k++;
            delay = $urandom_range(1, max_delay);
            phase = P_HOLD;
          end
        end
        P_HOLD: begin
          if (reset_at_word > 0 && k == reset_at_word) begin
            sys_rst_n = 1'b0;
            #1;
            checkOutput({tag, " reset en_write_fill"}, bus.en_write_fill, 1'b0);
            checkOutput({tag, " reset fill_data"}, bus.fill_data, 9'h000);
            checkOutput({tag, " reset busy"}, bus.busy, 1'b0);
            checkOutput({tag, " reset fill_done"}, bus.fill_done, 1'b0);
            @(negedge sys_clk);
            sys_rst_n = 1'b1;
            finished = 1;
          end else begin
            checkOutput({tag, " no strobe while waiting"}, bus.en_write_fill, 1'b0);
            checkOutput({tag, " data held"}, bus.fill_data, held);
            checkOutput({tag, " busy while waiting"}, bus.busy, 1'b1);
            delay--;
            if (delay == 0) begin
              bus.wr_done = 1'b1;
              phase = (k == exp_q.size()) ? P_DONE : P_STROBE;
            end
          end
        end
        P_DONE: begin
          checkOutput({tag, " fill_done"}, bus.fill_done, 1'b1);
          checkOutput({tag, " busy at done"}, bus.busy, 1'b0);
          checkOutput({tag, " no strobe at done"}, bus.en_write_fill, 1'b0);
          if (pulse_in_done) begin
            bus.fill_flag = 1'b1;
            bus.x0 = 8'd1; bus.y0 = 8'd1; bus.x1 = 8'd2; bus.y1 = 8'd2;
          end
          phase = P_AFTER;
        end
        default: begin
          checkOutput({tag, " fill_done cleared"}, bus.fill_done, 1'b0);
          checkOutput({tag, " idle busy"}, bus.busy, 1'b0);
          checkOutput({tag, " idle no strobe"}, bus.en_write_fill, 1'b0);
          finished = 1;
        end
      endcase
      cycles++;
      if (!finished) @(negedge sys_clk);
    end
    bus.fill_flag = 1'b0;
    bus.wr_done   = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got %0d strobes, expected %0d", tag, k, exp_q.size());
      doReset();
    end
    strobes = k;
  endtask

  initial begin
    vec_t vecs[6];
    int   n;
    logic [7:0] rx0, ry0, rx1, ry1;
    logic [15:0] rcol;

    vecs[0] = '{"2x3",      8'd0,   8'd0,   8'd1,   8'd2,   16'h07E0, 3,  23};
    vecs[1] = '{"invalid",  8'd10,  8'd0,   8'd9,   8'd0,   16'hFFFF, 1,  0};
    vecs[2] = '{"wrap",     8'd250, 8'd252, 8'd255, 8'd255, 16'h1234, 40, 59};
    vecs[3] = '{"fullrow",  8'd0,   8'd9,   8'd255, 8'd9,   16'hA5C3, 1,  523};
    vecs[4] = '{"tworows",  8'd0,   8'd0,   8'd255, 8'd1,   16'h5A3C, 1,  1035};
    vecs[5] = '{"column",   8'd3,   8'd0,   8'd3,   8'd5,   16'h0F0F, 5,  23};

    checks = 0; errors = 0;
    bus.fill_flag = 1'b0; bus.wr_done = 1'b0;
    bus.x0 = 8'd0; bus.y0 = 8'd0; bus.x1 = 8'd0; bus.y1 = 8'd0; bus.color = 16'd0;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    checkOutput("reset fill_data", bus.fill_data, 9'h000);
    checkOutput("reset en_write_fill", bus.en_write_fill, 1'b0);
    checkOutput("reset busy", bus.busy, 1'b0);
    checkOutput("reset fill_done", bus.fill_done, 1'b0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // 1x1 fill against the literal word stream.
    exp_q = '{9'h02A, 9'h100, 9'h107, 9'h100, 9'h107, 9'h02B, 9'h100, 9'h10A,
              9'h100, 9'h10A, 9'h02C, 9'h1F8, 9'h100};
    runFill("1x1", 8'd5, 8'd7, 8'd5, 8'd7, 16'hF800, 1, -1, 1'b0, 0, n);
    checkOutput("1x1 word count", n, 13);

    // Table of windows checked against the model stream.
    for (int i = 0; i < 6; i++) begin
      buildExpected(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].color);
      runFill(vecs[i].name, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1,
              vecs[i].color, vecs[i].max_delay, -1, 1'b0, 0, n);
      checkOutput({vecs[i].name, " word count"}, n, vecs[i].exp_words);
    end

    // Spurious wr_done while idle must produce nothing.
    @(negedge sys_clk);
    bus.wr_done = 1'b1;
    @(negedge sys_clk);
    bus.wr_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("idle wr_done no strobe", bus.en_write_fill, 1'b0);
      checkOutput("idle wr_done no done", bus.fill_done, 1'b0);
      checkOutput("idle wr_done not busy", bus.busy, 1'b0);
      @(negedge sys_clk);
    end

    // Start pulse mid-stream and in the fill_done cycle are both ignored.
    buildExpected(8'd20, 8'd30, 8'd22, 8'd31, 16'hBEEF);
    runFill("midpulse", 8'd20, 8'd30, 8'd22, 8'd31, 16'hBEEF, 4, 25, 1'b1, 0, n);
    checkOutput("midpulse word count", n, exp_q.size());

    // Reset during the pixel phase, then a clean restart.
    buildExpected(8'd0, 8'd0, 8'd3, 8'd3, 16'h1357);
    runFill("reset", 8'd0, 8'd0, 8'd3, 8'd3, 16'h1357, 3, -1, 1'b0, 15, n);
    exp_q = '{9'h02A, 9'h100, 9'h107, 9'h100, 9'h107, 9'h02B, 9'h100, 9'h10A,
              9'h100, 9'h10A, 9'h02C, 9'h1F8, 9'h100};
    runFill("restart", 8'd5, 8'd7, 8'd5, 8'd7, 16'hF800, 2, -1, 1'b0, 0, n);
    checkOutput("restart word count", n, 13);

    // Randomized windows under random back-pressure.
    for (int i = 0; i < 10; i++) begin
      rx0  = 8'($urandom_range(1, 250));
      ry0  = 8'($urandom_range(1, 250));
      rx1  = rx0 + 8'($urandom_range(0, 3));
      ry1  = ry0 + 8'($urandom_range(0, 3));
      rcol = 16'($urandom);
      if (i % 5 == 4) begin
        if (i == 4) rx1 = rx0 - 8'd1;
        else        ry1 = ry0 - 8'd1;
      end
      buildExpected(rx0, ry0, rx1, ry1, rcol);
      runFill("random", rx0, ry0, rx1, ry1, rcol, 40, (i == 2) ? 30 : -1, 1'b0, 0, n);
      checkOutput("random word count", n, exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_fill_rect.md
Name: lcd_fill_rect

Overview:
- Rectangle-fill engine for the ST7735 SPI LCD path; sits directly upstream of the SPI byte writer, alongside the character renderer.
- On a start pulse it latches a window and an RGB565 colour, then emits the word stream CASET, RASET, RAMWR and W*H pixels.
- Each word is a 9-bit {dc, byte} word and is handed over with the en_write/wr_done handshake.
- Used for screen clears, background panels and alarm highlight boxes.

Parameters:
- X_OFFSET, 8'd2: panel column offset added to x coordinates in CASET.
- Y_OFFSET, 8'd3: panel row offset added to y coordinates in RASET.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- fill_flag  in  1  one-cycle start request.
- x0  in  8  left column, inclusive.
- y0  in  8  top row, inclusive.
- x1  in  8  right column, inclusive.
- y1  in  8  bottom row, inclusive.
- color  in  16  RGB565 fill colour.
- wr_done  in  1  one-cycle pulse from the SPI writer: current word fully shifted out.
- fill_data  out  9  word to writer; bit8 = dc (0 = command, 1 = data), bits7:0 = byte.
- en_write_fill  out  1  one-cycle write strobe for fill_data.
- busy  out  1  high from the cycle after accept until fill_done.
- fill_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state): state=IDLE; fill_data=9'h000; en_write_fill=0; busy=0; fill_done=0; all counters and latches cleared.
- Accept: fill_flag=1 in IDLE latches x0, y0, x1, y1 and color.
  - fill_flag while busy, or in the fill_done cycle, is ignored.
  - Input changes after accept have no effect.
- Invalid window (x1<x0 or y1<y0):
  - No words are emitted.
  - The cycle after accept: fill_done=1 and busy stays 0.
  - The FSM returns to IDLE.
- States:
  - IDLE
  - ISSUE: drive fill_data and pulse en_write_fill for 1 cycle.
  - WAIT: hold fill_data stable and wait for wr_done.
  - NEXT: advance the sequence index or pixel counters.
  - DONE
- Transitions: ISSUE->WAIT always; WAIT->ISSUE on wr_done (bypassing NEXT is allowed if the index is advanced combinationally).
- Throughput: next en_write_fill comes exactly 1 cycle after the wr_done cycle.
- First strobe: the cycle after accept, with busy=1 in the same cycle.
- wr_done is sampled only in WAIT; it is ignored in IDLE, ISSUE and DONE.
- Header sequence (11 words, index 0..10):
  - 0x02A (CASET), 0x100, {1,x0+X_OFFSET}, 0x100, {1,x1+X_OFFSET}
  - 0x02B (RASET), 0x100, {1,y0+Y_OFFSET}, 0x100, {1,y1+Y_OFFSET}
  - 0x02C (RAMWR)
  - Offset sums are 8-bit, modulo 256; the high coordinate byte is always 0x00.
- Pixel phase: for each pixel, send {1,color[15:8]} then {1,color[7:0]}.
  - Column counter runs 0..x1-x0; row counter runs 0..y1-y0.
  - Column wraps to 0 and row increments after the last column.
  - Phase ends after the low byte of pixel (x1-x0, y1-y0) is acknowledged.
  - Full 256x256 is legal (65536 pixels); counters are 8-bit each plus a last-flag, with no overflow.
- Completion: the cycle after the final wr_done, fill_done=1 and busy=0; then IDLE.
- Total words = 11 + 2*(x1-x0+1)*(y1-y0+1).
- Outputs are registered; fill_data retains its last value in IDLE (don't-care when en_write_fill=0).
- The writer may take any number of cycles (≥1) per word; no timeout.

Test Plan:
- 1x1 fill (x0=x1=5, y0=y1=7, color=16'hF800):
  - Stream: 02A,100,107,100,107,02B,100,10A,100,10A,02C,1F8,100.
  - 13 strobes; fill_done one cycle after the 13th wr_done.
- 2x3 fill (x0=0, x1=1, y0=0, y1=2, color=16'h07E0):
  - 11 header words, then 6 pairs of 107,1E0 (23 strobes).
  - busy high throughout.
- Invalid window (x0=10, x1=9):
  - No en_write_fill.
  - fill_done at accept+1 with busy low.
- Back-pressure: wr_done returned after random delays of 1..40 cycles.
  - fill_data stable between each strobe and its wr_done.
  - Exactly one strobe per word; next strobe exactly 1 cycle after wr_done.
- fill_flag pulsed mid-operation with different coordinates and colour:
  - Ignored; the stream continues unchanged.
  - A spurious wr_done in IDLE produces no output.
- sys_rst_n asserted during the pixel phase:
  - All outputs 0 immediately.
  - After release, a new fill_flag restarts cleanly from 02A.
